// File: rtl/csi_rx_raw10_depacker_pkg.sv
// rtl/csi_rx_raw10_depacker_pkg.sv - shared RAW10 pixel types and packing constants
package csi_rx_raw10_depacker_pkg;

    typedef logic [9:0] pix10_t;
    typedef pix10_t [3:0] pix_quad_t;

    localparam int RAW10_BYTES_PER_QUAD = 5;
    localparam int RAW10_GROUP_BITS     = 8 * RAW10_BYTES_PER_QUAD;
    localparam int BYTE_BUF_BYTES       = 6;
    localparam int BYTE_BUF_BITS        = 8 * BYTE_BUF_BYTES;

    typedef logic [RAW10_GROUP_BITS-1:0] raw10_group_t;

endpackage

// File: rtl/csi_rx_raw10_unpack.sv
// rtl/csi_rx_raw10_unpack.sv - combinational 5-byte RAW10 group to 4-pixel quad mapper
module csi_rx_raw10_unpack
    import csi_rx_raw10_depacker_pkg::*;
(
    input  logic [39:0] group_bytes,
    output logic [39:0] quad
);

    raw10_group_t grp;
    pix_quad_t    q;

    assign grp = group_bytes;

    // Byte 4 carries the two LSBs of each of the four preceding pixels.
    always_comb begin
        q = '0;
        for (int n = 0; n < 4; n++) begin
            q[n] = {grp[8*n +: 8], grp[32 + 2*n +: 2]};
        end
    end

    assign quad = q;

endmodule

// File: rtl/csi_rx_raw10_depacker.sv
// rtl/csi_rx_raw10_depacker.sv - 2-lane CSI-2 RAW10 depacker with line/frame timing and geometry
module csi_rx_raw10_depacker #(
    parameter int QUAD_CNT_W = 11,
    parameter int LINE_CNT_W = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [15:0]           payload_in,
    input  logic                  payload_valid,
    input  logic                  in_frame,
    output logic [39:0]           pix_out,
    output logic                  pix_valid,
    output logic                  line_start,
    output logic                  line_end,
    output logic                  frame_start,
    output logic                  frame_end,
    output logic [QUAD_CNT_W-1:0] quads_per_line,
    output logic [LINE_CNT_W-1:0] lines_per_frame,
    output logic                  err_partial
);
    import csi_rx_raw10_depacker_pkg::*;

    logic [BYTE_BUF_BITS-1:0] buf_q;
    logic [2:0]               cnt_q;
    logic                     pv_q;
    logic                     if_q;
    logic                     first_q;
    logic [QUAD_CNT_W-1:0]    quad_cnt_q;
    logic [LINE_CNT_W-1:0]    line_cnt_q;
    logic [QUAD_CNT_W-1:0]    quads_per_line_q;
    logic [LINE_CNT_W-1:0]    lines_per_frame_q;
    logic                     pix_valid_q;
    logic                     line_start_q;
    logic [39:0]              pix_q;

    logic [BYTE_BUF_BITS-1:0] merged;
    logic [3:0]               cnt_sum;
    logic                     emit;
    logic                     line_end_raw;
    logic                     fs_raw;
    logic                     fe_raw;
    logic                     count_line;
    logic [LINE_CNT_W-1:0]    line_cnt_inc;
    logic [BYTE_BUF_BITS-1:0] buf_d;
    logic [2:0]               cnt_d;
    logic                     first_d;
    logic [39:0]              quad;
    logic                     live;

    // Bytes above cnt_q are always zero, so the new word can simply be OR'd in.
    assign merged       = buf_q | (BYTE_BUF_BITS'(payload_in) << {cnt_q, 3'b000});
    assign cnt_sum      = {1'b0, cnt_q} + 4'd2;
    assign emit         = payload_valid && (cnt_sum >= 4'(RAW10_BYTES_PER_QUAD));
    assign line_end_raw = pv_q & ~payload_valid;
    assign fs_raw       = in_frame & ~if_q;
    assign fe_raw       = ~in_frame & if_q;
    // A line ending on the same cycle the frame closes still belongs to that frame.
    assign count_line   = line_end_raw & (in_frame | if_q);
    assign line_cnt_inc = (count_line && (line_cnt_q != '1)) ? line_cnt_q + LINE_CNT_W'(1)
                                                             : line_cnt_q;

    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (line_end_raw) begin
            buf_d = '0;
            cnt_d = 3'd0;
        end else if (payload_valid) begin
            if (emit) begin
                buf_d = merged >> RAW10_GROUP_BITS;
                cnt_d = 3'(cnt_sum - 4'(RAW10_BYTES_PER_QUAD));
            end else begin
                buf_d = merged;
                cnt_d = cnt_sum[2:0];
            end
        end
    end

    always_comb begin
        first_d = first_q;
        if (emit) begin
            first_d = 1'b0;
        end else if (line_end_raw || fs_raw) begin
            first_d = 1'b1;
        end
    end

    csi_rx_raw10_unpack u_unpack (
        .group_bytes (merged[RAW10_GROUP_BITS-1:0]),
        .quad        (quad)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            buf_q             <= '0;
            cnt_q             <= 3'd0;
            pv_q              <= 1'b0;
            if_q              <= 1'b0;
            first_q           <= 1'b1;
            quad_cnt_q        <= '0;
            line_cnt_q        <= '0;
            quads_per_line_q  <= '0;
            lines_per_frame_q <= '0;
            pix_valid_q       <= 1'b0;
            line_start_q      <= 1'b0;
            pix_q             <= '0;
        end else if (enable) begin
            buf_q        <= buf_d;
            cnt_q        <= cnt_d;
            pv_q         <= payload_valid;
            if_q         <= in_frame;
            first_q      <= first_d;
            pix_valid_q  <= emit;
            line_start_q <= emit & (first_q | fs_raw);
            if (emit) begin
                pix_q <= quad;
            end

            if (line_end_raw) begin
                quads_per_line_q <= quad_cnt_q;
                quad_cnt_q       <= '0;
            end else if (emit && (quad_cnt_q != '1)) begin
                quad_cnt_q <= quad_cnt_q + QUAD_CNT_W'(1);
            end

            if (fs_raw) begin
                line_cnt_q <= '0;
            end else begin
                line_cnt_q <= line_cnt_inc;
            end
            if (fe_raw) begin
                lines_per_frame_q <= line_cnt_inc;
            end
        end
    end

    // Pulses are only presented on enabled cycles so a stalled quad is seen exactly once.
    assign live            = enable & ~reset;
    assign pix_out         = pix_q;
    assign pix_valid       = live & pix_valid_q;
    assign line_start      = live & line_start_q;
    assign line_end        = live & line_end_raw;
    assign err_partial     = live & line_end_raw & (cnt_q != 3'd0);
    assign frame_start     = live & fs_raw;
    assign frame_end       = live & fe_raw;
    assign quads_per_line  = quads_per_line_q;
    assign lines_per_frame = lines_per_frame_q;

endmodule

// File: tb/tb_csi_rx_raw10_depacker.sv
// tb/tb_csi_rx_raw10_depacker.sv - self-checking bench for csi_rx_raw10_depacker
module tb_csi_rx_raw10_depacker;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] payload_in;
    logic        payload_valid;
    logic        in_frame;
    logic [39:0] pix_out;
    logic        pix_valid;
    logic        line_start;
    logic        line_end;
    logic        frame_start;
    logic        frame_end;
    logic [10:0] quads_per_line;
    logic [11:0] lines_per_frame;
    logic        err_partial;

    csi_rx_raw10_depacker dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .payload_in      (payload_in),
        .payload_valid   (payload_valid),
        .in_frame        (in_frame),
        .pix_out         (pix_out),
        .pix_valid       (pix_valid),
        .line_start      (line_start),
        .line_end        (line_end),
        .frame_start     (frame_start),
        .frame_end       (frame_end),
        .quads_per_line  (quads_per_line),
        .lines_per_frame (lines_per_frame),
        .err_partial     (err_partial)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [39:0] pix;
        bit          first;
    } exp_pix_t;

    typedef struct {
        int nq;
        bit err;
    } exp_line_t;

    exp_pix_t    exp_q[$];
    exp_line_t   exp_lines[$];
    int          exp_frames[$];
    logic [39:0] obs_pix[$];

    int total = 0;
    int bad   = 0;
    bit check_on = 0;
    int frame_lines = 0;
    int exp_fs = 0, exp_fe = 0;
    int fs_cnt = 0, fe_cnt = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Model: a line is a flat byte array; every complete 5-byte group yields one quad.
    task automatic send_line(input int nwords, input logic [7:0] start, input int stall_at,
                             input bit close_frame);
        logic [7:0] b[$];
        int         nbytes;
        exp_pix_t   e;
        exp_line_t  l;
        logic [7:0] lsb;
        nbytes = 2 * nwords;
        for (int i = 0; i < nbytes; i++) b.push_back(start + 8'(i));
        for (int q = 0; q < nbytes / 5; q++) begin
            lsb = b[5*q+4];
            e.pix = '0;
            for (int n = 0; n < 4; n++) e.pix[10*n +: 10] = {b[5*q+n], lsb[2*n +: 2]};
            e.first = (q == 0);
            exp_q.push_back(e);
        end
        l.nq  = nbytes / 5;
        l.err = (nbytes % 5) != 0;
        exp_lines.push_back(l);
        if (in_frame) frame_lines++;
        for (int w = 0; w < nwords; w++) begin
            if (w == stall_at) begin
                enable = 1'b0;
                idle(3);
                enable = 1'b1;
            end
            payload_in    = {b[2*w+1], b[2*w]};
            payload_valid = 1'b1;
            @(posedge clock);
            #1;
        end
        payload_valid = 1'b0;
        if (close_frame) begin
            in_frame = 1'b0;
            exp_frames.push_back(frame_lines);
            exp_fe++;
        end
        idle(4);
    endtask

    task automatic start_frame();
        in_frame    = 1'b1;
        frame_lines = 0;
        exp_fs++;
        idle(3);
    endtask

    task automatic end_frame();
        in_frame = 1'b0;
        exp_frames.push_back(frame_lines);
        exp_fe++;
        idle(3);
    endtask

    initial begin : compare
        bit        pend_qpl_v, pend_lpf_v;
        int        pend_qpl, pend_lpf;
        exp_pix_t  e;
        exp_line_t l;
        pend_qpl_v = 0;
        pend_lpf_v = 0;
        pend_qpl   = 0;
        pend_lpf   = 0;
        forever begin
            @(negedge clock);
            if (check_on && !reset) begin
                if (pend_qpl_v) begin
                    chk("quads_per_line", 64'(quads_per_line), 64'(pend_qpl));
                    pend_qpl_v = 0;
                end
                if (pend_lpf_v) begin
                    chk("lines_per_frame", 64'(lines_per_frame), 64'(pend_lpf));
                    pend_lpf_v = 0;
                end
                if (!enable)
                    chk("stall_quiet", {pix_valid, line_start, line_end, err_partial,
                                        frame_start, frame_end}, 64'd0);
                if (pix_valid) begin
                    obs_pix.push_back(pix_out);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pix_valid", 64'(pix_valid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pix_out", 64'(pix_out), 64'(e.pix));
                        chk("line_start", 64'(line_start), 64'(e.first));
                    end
                end else if (line_start) begin
                    chk("line_start_without_pix", 64'(line_start), 64'd0);
                end
                if (line_end) begin
                    if (exp_lines.size() == 0) begin
                        chk("unexpected_line_end", 64'(line_end), 64'd0);
                    end else begin
                        l = exp_lines.pop_front();
                        chk("err_partial", 64'(err_partial), 64'(l.err));
                        pend_qpl   = l.nq;
                        pend_qpl_v = 1;
                    end
                end else if (err_partial) begin
                    chk("err_without_line_end", 64'(err_partial), 64'd0);
                end
                if (frame_start) fs_cnt++;
                if (frame_end) begin
                    fe_cnt++;
                    if (exp_frames.size() == 0) begin
                        chk("unexpected_frame_end", 64'(frame_end), 64'd0);
                    end else begin
                        pend_lpf   = exp_frames.pop_front();
                        pend_lpf_v = 1;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int base;
        reset         = 1'b1;
        enable        = 1'b1;
        payload_in    = '0;
        payload_valid = 1'b0;
        in_frame      = 1'b0;
        @(negedge clock);
        chk("reset_pulses", {pix_valid, line_start, line_end, err_partial, frame_start,
                             frame_end}, 64'd0);
        chk("reset_pix_out", 64'(pix_out), 64'd0);
        chk("reset_geometry", {quads_per_line, lines_per_frame}, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(2);
        check_on = 1;

        // 1: ten bytes 00..09
        base = obs_pix.size();
        send_line(5, 8'h00, -1, 0);
        chk("t1_quad_count", 64'(obs_pix.size() - base), 64'd2);
        chk("t1_quad0", 64'(obs_pix[base]),   64'({10'd12, 10'd8, 10'd5, 10'd0}));
        chk("t1_quad1", 64'(obs_pix[base+1]), 64'({10'd32, 10'd28, 10'd26, 10'd21}));
        chk("t1_qpl", 64'(quads_per_line), 64'd2);

        // 2: partial line then a clean one
        base = obs_pix.size();
        send_line(4, 8'h10, -1, 0);
        chk("t2_quad_count", 64'(obs_pix.size() - base), 64'd1);
        chk("t2_quad0", 64'(obs_pix[base]), 64'({10'd76, 10'd73, 10'd69, 10'd64}));
        chk("t2_qpl", 64'(quads_per_line), 64'd1);
        send_line(5, 8'h30, -1, 0);
        chk("t2_next_qpl", 64'(quads_per_line), 64'd2);

        // 3: frame of three 1280-pixel lines
        base = obs_pix.size();
        start_frame();
        send_line(800, 8'h40, -1, 0);
        send_line(800, 8'h80, -1, 0);
        send_line(800, 8'hC0, -1, 0);
        end_frame();
        chk("t3_pix_count", 64'(obs_pix.size() - base), 64'd960);
        chk("t3_qpl", 64'(quads_per_line), 64'd320);
        chk("t3_lpf", 64'(lines_per_frame), 64'd3);
        chk("t3_frame_starts", 64'(fs_cnt), 64'd1);
        chk("t3_frame_ends", 64'(fe_cnt), 64'd1);

        // 4: enable stall mid-line
        base = obs_pix.size();
        send_line(10, 8'h05, 4, 0);
        chk("t4_quad_count", 64'(obs_pix.size() - base), 64'd4);
        chk("t4_qpl", 64'(quads_per_line), 64'd4);

        // 5: reset after three words
        check_on = 0;
        for (int w = 0; w < 3; w++) begin
            payload_in    = {8'(2*w+1), 8'(2*w)};
            payload_valid = 1'b1;
            @(posedge clock);
            #1;
        end
        reset         = 1'b1;
        payload_valid = 1'b0;
        @(negedge clock);
        chk("t5_reset_pulses", {pix_valid, line_start, line_end, err_partial, frame_start,
                                frame_end}, 64'd0);
        chk("t5_reset_state", {pix_out, quads_per_line, lines_per_frame}, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(2);
        check_on = 1;
        base = obs_pix.size();
        send_line(5, 8'h00, -1, 0);
        chk("t5_quad0", 64'(obs_pix[base]), 64'({10'd12, 10'd8, 10'd5, 10'd0}));

        // 6: frame closes on the same cycle as line_end
        start_frame();
        send_line(5, 8'h50, -1, 0);
        send_line(5, 8'h60, -1, 1);
        chk("t6_lpf", 64'(lines_per_frame), 64'd2);

        idle(3);
        chk("pix_drained", 64'(exp_q.size()), 64'd0);
        chk("lines_drained", 64'(exp_lines.size()), 64'd0);
        chk("frames_drained", 64'(exp_frames.size()), 64'd0);
        chk("frame_start_total", 64'(fs_cnt), 64'(exp_fs));
        chk("frame_end_total", 64'(fe_cnt), 64'(exp_fe));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
